// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS receive channel with token-based word alignment and data/control decode
module tmds_decoder #(
   parameter int TOKEN_LOCK_COUNT = 8,
   parameter int SEARCH_TIMEOUT   = 2048,
   parameter int SLIP_WAIT        = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] control_out,
   output logic       de_out,
   output logic       locked_out,
   output logic       bitslip_out,
   output logic       lost_out
);
   localparam int CW = $clog2(SEARCH_TIMEOUT) + 1;
   localparam logic [1:0] S_SEARCH    = 2'd0;
   localparam logic [1:0] S_SLIP_WAIT = 2'd1;
   localparam logic [1:0] S_LOCKED    = 2'd2;
   localparam logic [CW-1:0] TIMER_LAST = CW'(SEARCH_TIMEOUT - 1);
   localparam logic [7:0] TOK_LAST = 8'(TOKEN_LOCK_COUNT - 1);
   localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);

   logic [1:0]    r_state;
   logic [7:0]    r_tok_cnt;
   logic [CW-1:0] r_timer;
   logic [CW-1:0] r_gap;
   logic [3:0]    r_wait;

   logic          w_is_tok;
   logic [1:0]    w_tok_ctl;
   logic [7:0]    w_q;
   logic [6:0]    w_x;
   logic [7:0]    w_d;
   logic          w_lock_hit;
   logic          w_timeout;
   logic          w_wait_done;
   logic          w_drop;
   logic          w_de;
   logic [1:0]    w_state_nxt;
   logic [7:0]    w_tok_inc;
   logic [CW-1:0] w_timer_inc;
   logic [CW-1:0] w_gap_inc;

   // Token recognition, data decode and FSM decisions for the word on the input this cycle
   always_comb begin
      w_is_tok    = (tmds_in == 10'h354) || (tmds_in == 10'h0AB) ||
                    (tmds_in == 10'h154) || (tmds_in == 10'h2AB);
      w_tok_ctl   = (tmds_in == 10'h0AB) ? 2'b01 :
                    (tmds_in == 10'h154) ? 2'b10 :
                    (tmds_in == 10'h2AB) ? 2'b11 : 2'b00;
      w_q         = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
      w_x         = w_q[7:1] ^ w_q[6:0];
      w_d         = {tmds_in[8] ? w_x : ~w_x, w_q[0]};
      w_tok_inc   = (&r_tok_cnt) ? r_tok_cnt : r_tok_cnt + 8'd1;
      w_timer_inc = (&r_timer) ? r_timer : r_timer + CW'(1);
      w_gap_inc   = (&r_gap) ? r_gap : r_gap + CW'(1);
      // lock takes priority over a coincident search timeout
      w_lock_hit  = (r_state == S_SEARCH) && w_is_tok && (r_tok_cnt == TOK_LAST);
      w_timeout   = (r_state == S_SEARCH) && !w_lock_hit && (r_timer == TIMER_LAST);
      w_wait_done = (r_state == S_SLIP_WAIT) && (r_wait == WAIT_LAST);
      // the word that brings the gap up to the timeout is the one that drops lock
      w_drop      = (r_state == S_LOCKED) && !w_is_tok && (r_gap == TIMER_LAST);
      w_de        = (r_state == S_LOCKED) && !w_is_tok && !w_drop;
      w_state_nxt = w_lock_hit  ? S_LOCKED :
                    w_timeout   ? S_SLIP_WAIT :
                    w_wait_done ? S_SEARCH :
                    w_drop      ? S_SEARCH :
                    (r_state == 2'd3) ? S_SEARCH : r_state;
   end

   // Alignment FSM and its counters; every counter clears when its state is left
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= S_SEARCH;
         r_tok_cnt <= '0;
         r_timer   <= '0;
         r_gap     <= '0;
         r_wait    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_tok_cnt <= (r_state == S_SEARCH && w_is_tok && !w_lock_hit) ? w_tok_inc : '0;
         r_timer   <= (r_state == S_SEARCH && !w_timeout && !w_lock_hit) ? w_timer_inc : '0;
         r_wait    <= (r_state == S_SLIP_WAIT && !w_wait_done) ? r_wait + 4'd1 : '0;
         r_gap     <= (r_state == S_LOCKED && !w_is_tok && !w_drop) ? w_gap_inc : '0;
      end
   end

   // Registered decode outputs and single-cycle status pulses
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         data_out    <= '0;
         control_out <= '0;
         de_out      <= 1'b0;
         locked_out  <= 1'b0;
         bitslip_out <= 1'b0;
         lost_out    <= 1'b0;
      end else begin
         data_out    <= w_de ? w_d : 8'h00;
         control_out <= w_is_tok ? w_tok_ctl : control_out;
         de_out      <= w_de;
         locked_out  <= w_lock_hit || (r_state == S_LOCKED && !w_drop);
         bitslip_out <= w_timeout;
         lost_out    <= w_drop;
      end
   end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized and directed checks of tmds_decoder against a behavioural model
module tb_tmds_decoder;
   localparam int TLC = 8;
   localparam int ST  = 32;
   localparam int SW  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] tmds_in = 10'h000;
   logic [7:0] data_out;
   logic [1:0] control_out;
   logic       de_out, locked_out, bitslip_out, lost_out;

   int total = 0;
   int bad = 0;

   typedef enum {M_HUNT, M_SETTLE, M_SYNC} mode_t;
   mode_t      m_mode;
   int         m_tok, m_timer, m_wait, m_gap, m_rot;
   logic [7:0] m_data;
   logic [1:0] m_ctl;
   logic       m_de, m_locked, m_slip, m_lost;
   logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   tmds_decoder #(.TOKEN_LOCK_COUNT(TLC), .SEARCH_TIMEOUT(ST), .SLIP_WAIT(SW)) dut (
      .clk_in(clk), .rst_in(rst), .tmds_in(tmds_in),
      .data_out(data_out), .control_out(control_out), .de_out(de_out),
      .locked_out(locked_out), .bitslip_out(bitslip_out), .lost_out(lost_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] decode(input logic [9:0] w);
      logic [7:0] q, d;
      for (int i = 0; i < 8; i++) q[i] = w[i] ^ w[9];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = (q[i] ^ q[i-1]) ^ ~w[8];
      return d;
   endfunction

   function automatic logic [9:0] rotate(input logic [9:0] w, input int k);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[(i + k) % 10] = w[i];
      return r;
   endfunction

   task automatic model_reset();
      m_mode = M_HUNT; m_tok = 0; m_timer = 0; m_wait = 0; m_gap = 0;
      m_data = 0; m_ctl = 0; m_de = 0; m_locked = 0; m_slip = 0; m_lost = 0;
   endtask

   task automatic model_edge(input logic [9:0] w);
      bit tok;
      logic [1:0] c;
      tok = 0; c = 0;
      for (int i = 0; i < 4; i++) if (w == tok_tab[i]) begin tok = 1; c = 2'(i); end
      if (tok) m_ctl = c;
      m_slip = 0; m_lost = 0; m_de = 0; m_data = 0;
      case (m_mode)
         M_HUNT: begin
            if (tok && m_tok == TLC - 1) begin
               m_mode = M_SYNC; m_locked = 1; m_gap = 0;
            end else if (m_timer == ST - 1) begin
               m_slip = 1; m_mode = M_SETTLE; m_wait = 0;
            end else m_timer++;
            m_tok = tok ? m_tok + 1 : 0;
         end
         M_SETTLE: begin
            m_wait++;
            if (m_wait == SW) begin m_mode = M_HUNT; m_timer = 0; m_tok = 0; end
         end
         default: begin
            if (tok) m_gap = 0;
            else begin
               m_gap++;
               if (m_gap == ST) begin
                  m_lost = 1; m_locked = 0; m_mode = M_HUNT; m_timer = 0; m_tok = 0;
               end else begin
                  m_de = 1; m_data = decode(w);
               end
            end
         end
      endcase
   endtask

   // present one word through the deserializer model and advance one clock
   task automatic step(input logic [9:0] w);
      logic [9:0] v;
      v = rotate(w, m_rot);
      tmds_in = v;
      @(posedge clk);
      model_edge(v);
      if (m_slip) m_rot = (m_rot + 1) % 10;
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset_state();
      model_reset();
      m_rot = 0;
      #1 rst = 1'b1;
      #1;
      total++;
      if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !== 14'h0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=0", {data_out, control_out, de_out, locked_out, bitslip_out, lost_out});
      end
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_aligned_lock();
      logic [9:0] seq [11] = '{10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354,
                               10'h354, 10'h354, 10'h100, 10'h200, 10'h2AB};
      for (int i = 0; i < 11; i++) begin
         step(seq[i]);
         total++;
         if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !==
             {m_data, m_ctl, m_de, m_locked, m_slip, m_lost}) begin
            bad++;
            $display("FAIL aligned_model i=%0d got=%h exp=%h", i,
                     {data_out, control_out, de_out, locked_out, bitslip_out, lost_out},
                     {m_data, m_ctl, m_de, m_locked, m_slip, m_lost});
         end
         if (i == 6) begin
            total++;
            if (locked_out !== 1'b0) begin bad++; $display("FAIL early_lock got=%b exp=0", locked_out); end
         end
         if (i == 7) begin
            total++;
            if ({locked_out, control_out, de_out} !== 4'b1000) begin
               bad++; $display("FAIL lock_8th got=%b exp=1000", {locked_out, control_out, de_out});
            end
         end
         if (i == 8) begin
            total++;
            if ({de_out, data_out} !== 9'h100) begin bad++; $display("FAIL data_00 got=%h exp=100", {de_out, data_out}); end
         end
         if (i == 9) begin
            total++;
            if ({de_out, data_out} !== 9'h1FF) begin bad++; $display("FAIL data_ff got=%h exp=1ff", {de_out, data_out}); end
         end
         if (i == 10) begin
            total++;
            if ({de_out, control_out, data_out} !== 11'h300) begin
               bad++; $display("FAIL ctl_11 got=%h exp=300", {de_out, control_out, data_out});
            end
         end
      end
   endtask

   task automatic test_random_data();
      logic [9:0] w;
      for (int i = 0; i < 192; i++) begin
         w = (i % 16 == 15) ? tok_tab[$urandom_range(0, 3)] : 10'($urandom);
         step(w);
         total++;
         if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !==
             {m_data, m_ctl, m_de, m_locked, m_slip, m_lost}) begin
            bad++;
            $display("FAIL random_data w=%h got=%h exp=%h", w,
                     {data_out, control_out, de_out, locked_out, bitslip_out, lost_out},
                     {m_data, m_ctl, m_de, m_locked, m_slip, m_lost});
         end
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !== 14'h0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {data_out, control_out, de_out, locked_out, bitslip_out, lost_out});
      end
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_loss();
      for (int i = 0; i < 8; i++) step(10'h354);
      total++;
      if (locked_out !== 1'b1) begin bad++; $display("FAIL loss_prelock got=%b exp=1", locked_out); end
      for (int i = 1; i <= 33; i++) begin
         step(10'h100);
         total++;
         if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !==
             {m_data, m_ctl, m_de, m_locked, m_slip, m_lost}) begin
            bad++;
            $display("FAIL loss_model i=%0d got=%h exp=%h", i,
                     {data_out, control_out, de_out, locked_out, bitslip_out, lost_out},
                     {m_data, m_ctl, m_de, m_locked, m_slip, m_lost});
         end
         total++;
         if ({lost_out, locked_out} !== ((i == 32) ? 2'b10 : (i < 32) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL loss_pulse i=%0d got=%b", i, {lost_out, locked_out});
         end
      end
      for (int i = 2; i <= 32; i++) begin
         step(10'h100);
         total++;
         if ({bitslip_out, de_out} !== {1'(i == 32), 1'b0}) begin
            bad++; $display("FAIL loss_reslip k=%0d got=%b exp=%b", i, {bitslip_out, de_out}, {1'(i == 32), 1'b0});
         end
      end
   endtask

   task automatic test_misalign();
      int last, nslip;
      bit done;
      do_reset();
      m_rot = 3; last = -1; nslip = 0; done = 0;
      for (int t = 1; t <= 500; t++) begin
         step(10'h354);
         total++;
         if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !==
             {m_data, m_ctl, m_de, m_locked, m_slip, m_lost}) begin
            bad++;
            $display("FAIL misalign_model t=%0d got=%h exp=%h", t,
                     {data_out, control_out, de_out, locked_out, bitslip_out, lost_out},
                     {m_data, m_ctl, m_de, m_locked, m_slip, m_lost});
         end
         if (bitslip_out === 1'b1) begin
            nslip++;
            total++;
            if (t - last != ((last < 0) ? 33 : 36)) begin
               bad++; $display("FAIL slip_spacing t=%0d prev=%0d", t, last);
            end
            last = t;
         end
         if (locked_out === 1'b1) begin done = 1; break; end
      end
      total++;
      if (!done || nslip > 9 || nslip == 0) begin
         bad++; $display("FAIL misalign_lock locked=%0d slips=%0d exp locked=1 slips 1..9", done, nslip);
      end
      for (int t = 0; t < 80; t++) begin
         step(10'h354);
         total++;
         if ({locked_out, bitslip_out} !== 2'b10) begin
            bad++; $display("FAIL post_lock_slip t=%0d got=%b exp=10", t, {locked_out, bitslip_out});
         end
      end
   endtask

   task automatic test_coincide();
      do_reset();
      m_rot = 0;
      for (int i = 0; i < 24; i++) step(10'($urandom_range(0, 255)) | 10'h100);
      for (int i = 0; i < 8; i++) begin
         step(10'h354);
         total++;
         if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !==
             {m_data, m_ctl, m_de, m_locked, m_slip, m_lost}) begin
            bad++;
            $display("FAIL coincide_model i=%0d got=%h exp=%h", i,
                     {data_out, control_out, de_out, locked_out, bitslip_out, lost_out},
                     {m_data, m_ctl, m_de, m_locked, m_slip, m_lost});
         end
      end
      total++;
      if ({locked_out, bitslip_out} !== 2'b10) begin
         bad++; $display("FAIL coincide got=%b exp=10", {locked_out, bitslip_out});
      end
      step(10'h354);
      total++;
      if (bitslip_out !== 1'b0) begin bad++; $display("FAIL coincide_after got=%b exp=0", bitslip_out); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      m_rot = 0;
      for (int i = 1; i <= 34; i++) begin
         step(10'h100);
         if (i == 32) begin
            total++;
            if (bitslip_out !== 1'b1) begin bad++; $display("FAIL wait_slip got=%b exp=1", bitslip_out); end
         end
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({data_out, control_out, de_out, locked_out, bitslip_out, lost_out} !== 14'h0) begin
         bad++;
         $display("FAIL wait_reset got=%h exp=0", {data_out, control_out, de_out, locked_out, bitslip_out, lost_out});
      end
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      m_rot = 0;
      for (int i = 1; i <= 12; i++) begin
         step(10'h154);
         total++;
         if ({control_out, locked_out, bitslip_out} !== {2'b10, 1'(i >= 8), 1'b0}) begin
            bad++; $display("FAIL wait_relock i=%0d got=%b exp=%b", i,
                            {control_out, locked_out, bitslip_out}, {2'b10, 1'(i >= 8), 1'b0});
         end
      end
   endtask

   initial begin
      test_reset_state();
      test_aligned_lock();
      test_random_data();
      test_reset();
      test_loss();
      test_misalign();
      test_coincide();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
